// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_ctrl_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StKill
    } fetch_state_e;

    localparam logic [63:0] ResetPcDefault = 64'h8000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] NopInst = 32'h0000_0013;

    // Fetch addresses are always word aligned.
    localparam logic [63:0] PcAlignMask = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/fetch_buf.sv
// One-entry pc/instruction holding register. Absorbs a response that arrives
// while the IF/ID output slot is still occupied.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned Xlen = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            flush_i,
    input  logic [Xlen-1:0] pc_i,
    input  logic [31:0]     inst_i,
    output logic            valid_o,
    output logic [Xlen-1:0] pc_o,
    output logic [31:0]     inst_o
);

    logic            valid_q;
    logic [Xlen-1:0] pc_q;
    logic [31:0]     inst_q;

    // Flush beats load beats drain; contents are only meaningful while valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NopInst;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps at most one memory
// request in flight, and hands (pc, inst) pairs to ID under valid/ready.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ResetPcDefault)
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    output logic [XLEN-1:0] pc_plus_4
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            if_valid_q;
    logic [XLEN-1:0] if_pc_q;
    logic [31:0]     if_inst_q;

    logic            buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_inst;
    logic            buf_load;
    logic            buf_drain;
    logic            buf_flush;

    logic            redirect_act;
    logic            out_fire;
    logic            slot_free;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] redirect_tgt;

    // Handshake qualifiers and hold-buffer controls.
    always_comb begin
        redirect_act = redirect_valid && (state_q != StIdle);
        out_fire     = if_valid_q && id_ready;
        slot_free    = !if_valid_q || id_ready;
        pc_seq       = pc_q + XLEN'(4);
        redirect_tgt = redirect_pc & PcAlignMask[XLEN-1:0];
        buf_flush    = redirect_act;
        buf_load     = !redirect_act && (state_q == StWait) && imem_rsp_valid && !slot_free;
        buf_drain    = !redirect_act && (state_q == StHold) && buf_valid && id_ready;
    end

    fetch_buf #(
        .Xlen (XLEN)
    ) u_hold_buf (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .flush_i (buf_flush),
        .pc_i    (pc_q),
        .inst_i  (imem_rsp_data),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .inst_o  (buf_inst)
    );

    // Fetch FSM together with the PC and the IF/ID output registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= NopInst;
        end else begin
            // A consumed output empties the slot unless refilled below.
            if (out_fire) begin
                if_valid_q <= 1'b0;
            end
            if (redirect_act) begin
                pc_q       <= redirect_tgt;
                if_valid_q <= 1'b0;
                case (state_q)
                    // An accepted request still owes us a response.
                    StReq:   state_q <= imem_req_ready ? StKill : StReq;
                    StWait:  state_q <= imem_rsp_valid ? StReq : StKill;
                    StHold:  state_q <= StReq;
                    StKill:  state_q <= imem_rsp_valid ? StReq : StKill;
                    default: state_q <= StReq;
                endcase
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StReq;
                    StReq: begin
                        if (imem_req_ready) begin
                            state_q <= StWait;
                        end
                    end
                    StWait: begin
                        if (imem_rsp_valid) begin
                            pc_q <= pc_seq;
                            if (slot_free) begin
                                if_valid_q <= 1'b1;
                                if_pc_q    <= pc_q;
                                if_inst_q  <= imem_rsp_data;
                                state_q    <= StReq;
                            end else begin
                                state_q <= StHold;
                            end
                        end
                    end
                    StHold: begin
                        if (buf_valid && id_ready) begin
                            if_valid_q <= 1'b1;
                            if_pc_q    <= buf_pc;
                            if_inst_q  <= buf_inst;
                            state_q    <= StReq;
                        end
                    end
                    StKill: begin
                        if (imem_rsp_valid) begin
                            state_q <= StReq;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign imem_req_valid = (state_q == StReq);
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_inst        = if_inst_q;
    assign pc_plus_4      = if_pc_q + XLEN'(4);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a variable-latency instruction memory model.
module tb_fetch_ctrl;

    logic        sys_clk;
    logic        sys_rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [63:0] pc_plus_4;

    int checks = 0;
    int errors = 0;

    // Memory model state.
    int          lat = 1;
    int          wait_cnt = 0;
    logic        outstanding = 1'b0;
    logic [63:0] pend_addr = '0;

    typedef struct {
        logic        id_rdy;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_ifv;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [13];

    fetch_ctrl #(
        .XLEN     (64),
        .RESET_PC (64'h8000_0000)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .pc_plus_4      (pc_plus_4)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h00A0_0093;
        return {a[17:2], 16'h0093};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic exp_req,
                                 input logic [63:0] exp_addr, input logic exp_ifv,
                                 input logic [63:0] exp_pc, input logic [31:0] exp_inst);
        chk({name, "_req_valid"}, 64'(imem_req_valid), 64'(exp_req));
        if (exp_req) chk({name, "_req_addr"}, imem_req_addr, exp_addr);
        chk({name, "_if_valid"}, 64'(if_valid), 64'(exp_ifv));
        if (exp_ifv) begin
            chk({name, "_if_pc"}, if_pc, exp_pc);
            chk({name, "_if_inst"}, 64'(if_inst), 64'(exp_inst));
            chk({name, "_pc_plus_4"}, pc_plus_4, exp_pc + 64'd4);
        end
    endtask

    // One clock: sample handshakes before the edge, advance the memory model after it.
    task automatic tick();
        logic        hs;
        logic [63:0] a;
        logic        rsp_pre;
        hs      = imem_req_valid && imem_req_ready;
        a       = imem_req_addr;
        rsp_pre = imem_rsp_valid;
        @(posedge sys_clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (!sys_rst) begin
            wait_cnt    = 0;
            outstanding = 1'b0;
            return;
        end
        if (rsp_pre) outstanding = 1'b0;
        if (hs) begin
            checks++;
            if (outstanding) begin
                errors++;
                $display("FAIL one_outstanding: got second request at %h expected none", a);
            end
            outstanding = 1'b1;
            pend_addr   = a;
            wait_cnt    = lat;
        end
        if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
            end
        end
    endtask

    initial begin
        sys_rst        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Basic stream with 1-cycle memory, then a 5-cycle ID stall.
        vecs[0]  = '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, 32'h00A0_0093};
        vecs[3]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h0001_0093};
        vecs[5]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0004, 32'h0001_0093};
        vecs[6]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0004, 32'h0001_0093};
        vecs[7]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0004, 32'h0001_0093};
        vecs[8]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0004, 32'h0001_0093};
        vecs[9]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_0004, 32'h0001_0093};
        vecs[10] = '{1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008, 32'h0002_0093};
        vecs[11] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C, 32'h0003_0093};

        #1 sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_if_inst", 64'(if_inst), 64'h13);
        chk("rst_pc_plus_4", pc_plus_4, 64'h4);
        sys_rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            id_ready = vecs[i].id_rdy;
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                          vecs[i].exp_ifv, vecs[i].exp_pc, vecs[i].exp_inst);
        end

        // Redirect while waiting on a 3-cycle response; stale word is dropped.
        lat = 3;
        id_ready = 1'b0;
        tick();
        check_outputs("rdw_wait", 1'b0, 64'h0, 1'b1, 64'h8000_000C, 32'h0003_0093);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check_outputs("rdw_drop", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("rdw_kill", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("rdw_req", 1'b1, 64'h8000_0100, 1'b0, 64'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outputs($sformatf("rdw_pend%0d", i), 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        end
        tick();
        check_outputs("rdw_new", 1'b1, 64'h8000_0104, 1'b1, 64'h8000_0100, 32'h0040_0093);

        // Redirect in the same cycle the request is accepted.
        lat = 2;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        check_outputs("rrq_kill", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("rrq_kill2", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("rrq_req", 1'b1, 64'h8000_0200, 1'b0, 64'h0, 32'h0);

        // Redirect in the same cycle the response arrives.
        lat = 1;
        tick();
        check_outputs("rrs_wait", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        check_outputs("rrs_req", 1'b1, 64'h8000_0300, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("rrs_wait2", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("rrs_new", 1'b1, 64'h8000_0304, 1'b1, 64'h8000_0300, 32'h00C0_0093);

        // Top-of-space fetch wraps; low target bits are ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check_outputs("wrap_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("wrap_wait", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("wrap_out", 1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_0093);
        chk("wrap_pc_plus_4_zero", pc_plus_4, 64'h0);

        // Asynchronous reset in the middle of a WAIT.
        lat = 3;
        id_ready = 1'b0;
        tick();
        check_outputs("arst_wait", 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_0093);
        #2 sys_rst = 1'b0;
        imem_rsp_valid = 1'b0;
        wait_cnt       = 0;
        outstanding    = 1'b0;
        #1;
        chk("arst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("arst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("arst_if_valid", 64'(if_valid), 64'd0);
        chk("arst_if_pc", if_pc, 64'h0);
        chk("arst_if_inst", 64'(if_inst), 64'h13);
        chk("arst_pc_plus_4", pc_plus_4, 64'h4);
        @(posedge sys_clk); #1;
        sys_rst  = 1'b1;
        lat      = 1;
        id_ready = 1'b1;
        tick();
        check_outputs("post_req", 1'b1, 64'h8000_0000, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("post_wait", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
        tick();
        check_outputs("post_out", 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, 32'h00A0_0093);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch for the five-stage pipeline. Owns the architectural fetch PC and issues one-outstanding-request transactions to a variable-latency instruction memory. Delivers (pc, instruction) pairs to the IF/ID boundary under a valid/ready handshake. Applies stalls from ID and redirects from EX (taken branch/jump), and discards stale responses after a redirect.

Parameters:
XLEN, 64, address/PC width (matches `width).
RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
sys_clk  input  1  clock, rising edge.
sys_rst  input  1  asynchronous, active-low reset.
redirect_valid  input  1  EX requests a PC change this cycle.
redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (treated as 0).
id_ready  input  1  ID accepts the current fetch output (driven as ~stall_id_reg).
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  XLEN  fetch address, always 4-byte aligned.
imem_req_ready  input  1  memory accepts the request.
imem_rsp_valid  input  1  response valid; no backpressure, one response per accepted request, at least 1 cycle after acceptance.
imem_rsp_data  input  32  instruction word.
if_valid  output  1  if_pc/if_inst hold a valid fetched instruction.
if_pc  output  XLEN  PC of if_inst.
if_inst  output  32  fetched instruction.
pc_plus_4  output  XLEN  if_pc + 4, for link-address use downstream.

Behaviour:
- Reset (sys_rst=0, async): state=IDLE, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=32'h0000_0013 (NOP), pc_plus_4=4, hold buffer empty. Reset mid-transaction abandons it; no response is expected afterwards.
- States: IDLE, REQ, WAIT, HOLD, KILL.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT. Address stays stable while waiting, except on redirect.
- WAIT: on imem_rsp_valid:
  - If output slot is free (if_valid=0, or if_valid & id_ready): load if_pc=pc, if_inst=rsp_data, if_valid=1; pc<=pc+4; -> REQ.
  - Otherwise: capture the response into the hold buffer; pc<=pc+4; -> HOLD.
- HOLD: imem_req_valid=0. When id_ready: move the buffer to the output (if_valid stays 1), clear the buffer, -> REQ.
- KILL: a stale response is outstanding. On imem_rsp_valid, drop it and -> REQ.
- Output handshake: a transfer occurs when if_valid & id_ready. If no new data is loaded that cycle, if_valid<=0. if_* is held unchanged while if_valid & ~id_ready.
- Redirect (highest priority, any state except IDLE):
  - pc<=redirect_pc & ~3; if_valid<=0; hold buffer cleared.
  - REQ with no handshake that cycle: stay REQ; the new address appears next cycle.
  - REQ with imem_req_ready in the same cycle: the old request was accepted -> KILL.
  - WAIT without rsp_valid -> KILL. WAIT with rsp_valid in the same cycle: drop the response -> REQ.
  - HOLD -> REQ. KILL: stay KILL, update pc.
- Redirect and id_ready in the same cycle: the redirect wins; the current output is still considered consumed.
- Arithmetic: pc+4 and pc_plus_4 wrap modulo 2^XLEN (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
- Throughput: at most one instruction per 2 cycles with a 1-cycle memory (REQ, then WAIT). Latency from accepted request to if_valid is response latency + 1 cycle.
- Invariant: at most one outstanding memory request. imem_req_valid is never asserted in WAIT, HOLD or KILL.

Decomposition:
- Shared package: state encoding (IDLE, REQ, WAIT, HOLD, KILL), RESET_PC default, NOP encoding 32'h0000_0013, PC alignment mask.
- One sub-module, fetch_buf: a one-entry pc/inst holding register with valid, load, drain and flush controls. It is instantiated for the hold buffer.

Test Plan:
- Reset release, imem ready=1, 1-cycle response data 32'h00A0_0093 -> first req addr 8000_0000; if_valid=1 with if_pc=8000_0000 and if_inst=00A0_0093 two cycles after acceptance; next req addr 8000_0004.
- id_ready=0 for 5 cycles while responses arrive -> if_* frozen at 8000_0004; second word buffered (state HOLD), no new request; on id_ready=1, buffered 8000_0008 appears next cycle, then a request to 8000_000C.
- Redirect to 8000_0103 while in WAIT with a 3-cycle response -> if_valid drops next cycle; the stale response is discarded; next request addr 8000_0100; no instruction from the old path ever reaches if_valid.
- Redirect coincident with imem_req_ready in REQ -> KILL entered; one response dropped; request to the redirect target follows.
- Redirect coincident with rsp_valid in WAIT -> response dropped; state REQ next cycle with the new address; if_valid=0.
- pc=FFFF_FFFF_FFFF_FFFC fetch -> pc_plus_4=0; next req addr 0. Async reset asserted mid-WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.
